// File: rtl/irq_prio_ctrl4_pkg.sv
// irq_prio_ctrl4_pkg: shared types and constants for the 4-line interrupt priority controller
// Contents: state_t (IDLE=0, SERVE=1), NUM_IRQ request width, DEF_ACK_TIMEOUT default timeout
package irq_prio_ctrl4_pkg;
    typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;
    localparam int NUM_IRQ = 4;
    localparam int DEF_ACK_TIMEOUT = 15;
endpackage

// File: rtl/irq_prio_ctrl4_prio_enc4.sv
// prio_enc4: combinational fixed-priority encoder, bit 3 highest
// Ports: vec (in, 4) candidate lines; idx (out, 2) highest set index; any (out, 1) some bit set
module prio_enc4
    import irq_prio_ctrl4_pkg::*;
(
    input  logic [NUM_IRQ-1:0] vec,
    output logic [1:0]         idx,
    output logic               any
);
    assign any = |vec;
    always_comb idx = vec[3] ? 2'd3 : vec[2] ? 2'd2 : vec[1] ? 2'd1 : 2'd0;
endmodule

// File: rtl/irq_prio_ctrl4.sv
// irq_prio_ctrl4: rising-edge interrupt capture with fixed-priority presentation, ack and ack timeout
// Ports: clk, rst_n (sync active-low), req[3:0] raw lines, irq_ack consumer ack,
//        irq_valid/irq_id presented request, pending[3:0] captured requests, timeout one-cycle pulse
// Optional: IRQ_MASK_EN adds mask_we/mask_wdata and a mask register gating selection
module irq_prio_ctrl4
    import irq_prio_ctrl4_pkg::*;
#(
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] req,
    input  logic               irq_ack,
`ifdef IRQ_MASK_EN
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
`endif
    output logic               irq_valid,
    output logic [1:0]         irq_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               timeout
);
    state_t             state;
    logic [NUM_IRQ-1:0] req_d;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [7:0]         cnt;
    logic [1:0]         sel_id;
    logic               sel_any;
`ifdef IRQ_MASK_EN
    logic [NUM_IRQ-1:0] mask;
    always_ff @(posedge clk) begin
        if (!rst_n) mask <= '1;
        else if (mask_we) mask <= mask_wdata;
    end
    assign eligible = pending & mask;
`else
    assign eligible = pending;
`endif
    prio_enc4 u_enc (.vec(eligible), .idx(sel_id), .any(sel_any));
    assign irq_valid = (state == SERVE);
    assign clr = (state == SERVE && irq_ack) ? (NUM_IRQ'(1) << irq_id) : '0;
    // New rising edges are OR'd in after the ack clear so a coincident set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            req_d   <= '0;
            cnt     <= '0;
            irq_id  <= '0;
            timeout <= 1'b0;
        end else begin
            req_d   <= req;
            pending <= (pending & ~clr) | (req & ~req_d);
            timeout <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (sel_any) begin
                    state  <= SERVE;
                    irq_id <= sel_id;
                end
            end else if (irq_ack) begin
                state <= IDLE;
            end else if (cnt == 8'(ACK_TIMEOUT)) begin
                state   <= IDLE;
                timeout <= 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_irq_prio_ctrl4.sv
// tb_irq_prio_ctrl4: randomized and directed stimulus against a cycle reference model with scoreboard
module tb_irq_prio_ctrl4;
    localparam int TO = 3;

    typedef struct {
        logic       v;
        logic [1:0] id;
        logic [3:0] pend;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       irq_ack;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       timeout;
`ifdef IRQ_MASK_EN
    logic       mask_we;
    logic [3:0] mask_wdata;
`endif

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    logic [3:0] m_pend, m_prev, m_mask;
    logic       m_serv, m_to;
    logic [1:0] m_id;
    int         m_shown;

    irq_prio_ctrl4 #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .irq_ack(irq_ack),
`ifdef IRQ_MASK_EN
        .mask_we(mask_we),
        .mask_wdata(mask_wdata),
`endif
        .irq_valid(irq_valid),
        .irq_id(irq_id),
        .pending(pending),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a request is presented for at most TO+1 cycles; the highest
    // eligible pending line is chosen only from an idle cycle.
    task automatic model(input logic [3:0] r, input logic a, input logic rn);
        logic [3:0] nxt;
        int hit;
        hit = -1;
        if (!rn) begin
            m_pend = 4'b0; m_prev = 4'b0; m_serv = 1'b0; m_id = 2'd0;
            m_shown = 0; m_to = 1'b0; m_mask = 4'hF;
        end else begin
            nxt = m_pend;
            if (m_serv && a) nxt[m_id] = 1'b0;
            nxt = nxt | (r & ~m_prev);
            m_prev = r;
            m_to = 1'b0;
            if (!m_serv) begin
                for (int k = 3; k >= 0; k--)
                    if (hit < 0 && m_pend[k] && m_mask[k]) hit = k;
                if (hit >= 0) begin
                    m_serv = 1'b1;
                    m_id = 2'(hit);
                    m_shown = 1;
                end
            end else if (a) begin
                m_serv = 1'b0;
            end else if (m_shown == TO + 1) begin
                m_serv = 1'b0;
                m_to = 1'b1;
            end else begin
                m_shown++;
            end
`ifdef IRQ_MASK_EN
            if (mask_we) m_mask = mask_wdata;
`endif
            m_pend = nxt;
        end
        q.push_back('{m_serv, m_id, m_pend, m_to});
    endtask

    task automatic step(input logic [3:0] r, input logic a, input logic rn);
        req = r;
        irq_ack = a;
        rst_n = rn;
        @(posedge clk);
        model(r, a, rn);
        #2;
    endtask

    task automatic run(input logic [3:0] r, input logic a, input logic rn, input int n);
        for (int i = 0; i < n; i++) step(r, a, rn);
    endtask

    task automatic auto_ack(input int n);
        for (int i = 0; i < n; i++) step(4'b0, m_serv, 1'b1);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if ({irq_valid, irq_id, pending, timeout} !== {e.v, e.id, e.pend, e.to}) begin
                fails++;
                $display("FAIL outputs cycle %0d: valid/id/pending/timeout got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                         cyc, irq_valid, irq_id, pending, timeout, e.v, e.id, e.pend, e.to);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req = 4'b0;
        irq_ack = 1'b0;
        m_mask = 4'hF;
`ifdef IRQ_MASK_EN
        mask_we = 1'b0;
        mask_wdata = 4'hF;
`endif
        run(4'b0, 1'b0, 1'b0, 2);
        // single low-priority request, ack two cycles after presentation
        step(4'b0001, 1'b0, 1'b1);
        run(4'b0, 1'b0, 1'b1, 3);
        step(4'b0, 1'b1, 1'b1);
        run(4'b0, 1'b0, 1'b1, 2);
        // three simultaneous requests served 3, 2, 0
        step(4'b1101, 1'b0, 1'b1);
        step(4'b0, 1'b0, 1'b1);
        auto_ack(8);
        // no ack: timeout and re-presentation
        step(4'b0010, 1'b0, 1'b1);
        run(4'b0, 1'b0, 1'b1, 12);
        auto_ack(3);
        // re-rise on the ack edge keeps the bit pending
        step(4'b0010, 1'b0, 1'b1);
        run(4'b0, 1'b0, 1'b1, 2);
        step(4'b0010, 1'b1, 1'b1);
        run(4'b0, 1'b0, 1'b1, 2);
        auto_ack(3);
        // higher-priority arrival while serving does not pre-empt
        step(4'b0001, 1'b0, 1'b1);
        run(4'b0, 1'b0, 1'b1, 2);
        step(4'b1000, 1'b0, 1'b1);
        auto_ack(6);
        // reset while presenting
        step(4'b0100, 1'b0, 1'b1);
        run(4'b0, 1'b0, 1'b1, 2);
        step(4'b0, 1'b0, 1'b0);
        run(4'b0, 1'b0, 1'b1, 2);
`ifdef IRQ_MASK_EN
        mask_we = 1'b1; mask_wdata = 4'b0111;
        step(4'b0, 1'b0, 1'b1);
        mask_we = 1'b0;
        step(4'b1001, 1'b0, 1'b1);
        step(4'b0, 1'b0, 1'b1);
        auto_ack(4);
        mask_we = 1'b1; mask_wdata = 4'hF;
        step(4'b0, 1'b0, 1'b1);
        mask_we = 1'b0;
        auto_ack(4);
`endif
        for (int i = 0; i < 800; i++) begin
`ifdef IRQ_MASK_EN
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
`endif
            step(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 80) != 0));
        end
`ifdef IRQ_MASK_EN
        mask_we = 1'b0;
`endif
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/irq_prio_ctrl4.md
IRQ_PRIO_CTRL4 -- requirements
Module: irq_prio_ctrl4

Interface
REQ-001 The block SHALL provide parameter ACK_TIMEOUT, default 15, setting the maximum SERVE-state cycles without irq_ack (legal 1..255).
REQ-002 The block SHALL provide port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1: reset is synchronous and active-low.
REQ-004 The block SHALL provide port req, input, 4, raw request lines; bit 3 is highest priority, bit 0 lowest.
REQ-005 The block SHALL provide port irq_ack, input, 1, consumer acknowledge of the presented request.
REQ-006 The block SHALL provide port irq_valid, output, 1, request presented to the consumer.
REQ-007 The block SHALL provide port irq_id, output, 2, encoded index of the presented request.
REQ-008 The block SHALL provide port pending, output, 4, current pending-request register.
REQ-009 The block SHALL provide port timeout, output, 1, one-cycle pulse on ack timeout.
REQ-010 With IRQ_MASK_EN defined, the block SHALL add ports mask_we (input, 1) and mask_wdata (input, 4); otherwise these ports SHALL NOT exist.

Function
REQ-011 The block SHALL register req into req_d each cycle; pending[k] SHALL set on the edge where req[k]=1 and req_d[k]=0 (rising-edge capture).
REQ-012 Eligible requests SHALL be pending AND mask (mask all-ones without IRQ_MASK_EN).
REQ-013 The FSM SHALL have states IDLE and SERVE; reset state is IDLE.
REQ-014 In IDLE with any eligible bit, the next edge SHALL load irq_id with the highest eligible index and enter SERVE; with none eligible, it SHALL stay in IDLE.
REQ-015 irq_valid SHALL be 1 exactly when state is SERVE; irq_id SHALL stay stable throughout SERVE.
REQ-016 Latency: req rising sampled at edge N -> pending set after N -> irq_valid=1 after edge N+1.
REQ-017 In SERVE with irq_ack=1, the next edge SHALL clear pending[irq_id] and return to IDLE; irq_ack in IDLE SHALL be ignored.
REQ-018 The wait counter SHALL clear on entering SERVE and increment each SERVE cycle without ack; when it reaches ACK_TIMEOUT, the next edge SHALL return to IDLE with pending unchanged and timeout=1 for exactly that one cycle.
REQ-019 If ack and timeout coincide, ack SHALL win: pending is cleared and timeout stays 0.
REQ-020 If a new rising edge on bit k coincides with ack clearing bit k, set SHALL win and pending[k] SHALL remain 1.
REQ-021 A higher-priority request arriving during SERVE SHALL NOT pre-empt; it SHALL be served after the return to IDLE.
REQ-022 Back-to-back: after ack, at least one IDLE cycle (irq_valid=0) SHALL separate successive presentations.

Reset
REQ-023 With rst_n=0 at an edge, the block SHALL set state=IDLE, pending=0, req_d=0, counter=0, irq_id=0, irq_valid=0, timeout=0, and mask=4'b1111.
REQ-024 Reset asserted mid-SERVE SHALL discard the presented request without a timeout pulse.

Configuration
REQ-025 With macro IRQ_MASK_EN defined, mask SHALL load from mask_wdata on an edge with mask_we=1; masking SHALL hide pending bits from selection without clearing them.
REQ-026 A mask write during SERVE SHALL NOT affect the request being served.
REQ-027 Without IRQ_MASK_EN, the mask register SHALL be absent and all four bits always eligible.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=0, SERVE=1), the width constant 4, and the default ACK_TIMEOUT.
REQ-029 Priority selection SHALL be one combinational sub-module, prio_enc4 (4-bit in; 2-bit index and any-valid out; bit 3 highest priority).

Verification
REQ-030 req=0001 rising, ack 2 cycles after irq_valid -> irq_id=0, pending 0001->0000, timeout stays 0.
REQ-031 req 0101 and 1000 rising together -> served in order irq_id=3, 2, 0, with one IDLE cycle between each.
REQ-032 req=0010, no ack, ACK_TIMEOUT=3 -> irq_valid high 4 cycles, timeout pulse 1 cycle, pending stays 0010, re-presented.
REQ-033 During SERVE of id 1, req[1] re-rises on the ack edge -> pending[1]=1 afterwards, id 1 presented again.
REQ-034 rst_n=0 while irq_valid=1 -> next cycle all outputs 0, pending=0000.
REQ-035 With IRQ_MASK_EN, mask=0111 and req=1001 -> only id 0 served, pending[3] held; mask=1111 -> id 3 served.
